// File: rtl/mem_ctrl_p.sv
// Single-port word memory behind a wr/rd request / response handshake.
// It has byte strobes, a configurable read latency and a saturating count of errored requests.
module mem_ctrl_p #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    response,
    output logic                    err,
    output logic [7:0]              err_count
);

    // state   | meaning
    // IDLE    | ready=1, waiting for wr or rd
    // RD_WAIT | read accepted, counting down the remaining read latency
    // RESP    | response pulse cycle, back to IDLE next

    localparam int NB = DATA_WIDTH / 8;
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [1:0] WAIT_INIT = (RD_LATENCY > 2) ? 2'(RD_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [DATA_WIDTH-1:0] rd_buf;
    logic [1:0]            wait_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  req_err;

    assign idx     = addr[IDX_W-1:0];
    assign req_err = (wr && rd) || ({1'b0, addr} >= LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            response  <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            rd_buf    <= '0;
            err_count <= '0;
            wait_cnt  <= '0;
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[i] <= '0;
            end
        end else begin
            response <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr || rd) begin
                        ready <= 1'b0;
                        if (req_err) begin
                            state    <= RESP;
                            response <= 1'b1;
                            err      <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end else if (wr) begin
                            for (int b = 0; b < NB; b++) begin
                                if (wstrb[b]) begin
                                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                                end
                            end
                            state    <= RESP;
                            response <= 1'b1;
                        end else begin
                            // Data is snapshotted at acceptance and only shown at the response.
                            rd_buf <= mem[idx];
                            if (RD_LATENCY == 1) begin
                                rdata    <= mem[idx];
                                state    <= RESP;
                                response <= 1'b1;
                            end else begin
                                wait_cnt <= WAIT_INIT;
                                state    <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rdata    <= rd_buf;
                        response <= 1'b1;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_p.sv
// Bench for mem_ctrl_p: three instances (read latency 2, 1 and 4) share one stimulus stream.
// A transaction-level model is checked against them every cycle, with literal checks on top.
module tb_mem_ctrl_p;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  wstrb = '0;

    logic [2:0]  ready_v, response_v, err_v;
    logic [15:0] rdata_v [3];
    logic [7:0]  cnt_v [3];

    always #5 clk = ~clk;

    mem_ctrl_p #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_SIZE(16), .RD_LATENCY(2)) u_dut (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready_v[0]), .rdata(rdata_v[0]), .response(response_v[0]), .err(err_v[0]),
        .err_count(cnt_v[0]));

    mem_ctrl_p #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_SIZE(16), .RD_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready_v[1]), .rdata(rdata_v[1]), .response(response_v[1]), .err(err_v[1]),
        .err_count(cnt_v[1]));

    mem_ctrl_p #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_SIZE(16), .RD_LATENCY(4)) u_lat4 (
        .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready_v[2]), .rdata(rdata_v[2]), .response(response_v[2]), .err(err_v[2]),
        .err_count(cnt_v[2]));

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    // Transaction model: each request fixes the cycle of its response; busy until then.
    int          cyc = 0;
    int          resp_at [3];
    bit          resp_err [3];
    bit          resp_rd [3];
    logic [15:0] pend [3];
    logic [15:0] m_rdata [3];
    int          m_cnt [3];
    logic [15:0] m_mem [3][16];
    int          resp_cnt [3] = '{0, 0, 0};

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            resp_at[k]  = -1;
            resp_err[k] = 1'b0;
            resp_rd[k]  = 1'b0;
            pend[k]     = '0;
            m_rdata[k]  = '0;
            m_cnt[k]    = 0;
            for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
        end
    endtask

    always @(negedge reset) model_clear();

    always @(posedge clk) begin
        bit e;
        if (!reset) begin
            model_clear();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (cyc > resp_at[k] && (wr || rd)) begin
                    e = (wr && rd) || (addr >= 8'd16);
                    resp_err[k] = e;
                    resp_rd[k]  = rd && !e;
                    if (e) begin
                        resp_at[k] = cyc + 1;
                        if (m_cnt[k] < 255) m_cnt[k]++;
                    end else if (wr) begin
                        resp_at[k] = cyc + 1;
                        for (int b = 0; b < 2; b++)
                            if (wstrb[b]) m_mem[k][addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
                    end else begin
                        resp_at[k] = cyc + lat_of(k);
                        pend[k] = m_mem[k][addr[3:0]];
                    end
                end
            end
        end
        cyc++;
        for (int k = 0; k < 3; k++)
            if (cyc == resp_at[k] && resp_rd[k]) m_rdata[k] = pend[k];
    end

    always begin
        bit exp_resp;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_resp = (cyc == resp_at[k]);
            check($sformatf("ready[%0d]", k), 32'(ready_v[k]), 32'(cyc > resp_at[k]));
            check($sformatf("response[%0d]", k), 32'(response_v[k]), 32'(exp_resp));
            check($sformatf("err[%0d]", k), 32'(err_v[k]), 32'(exp_resp && resp_err[k]));
            check($sformatf("rdata[%0d]", k), 32'(rdata_v[k]), 32'(m_rdata[k]));
            check($sformatf("err_count[%0d]", k), 32'(cnt_v[k]), 32'(m_cnt[k]));
            if (response_v[k]) resp_cnt[k]++;
        end
    end

    int          got_lat;
    bit          got_err;
    logic [15:0] got_rdata;

    task automatic do_req(input bit w, input bit r, input logic [7:0] a,
                          input logic [15:0] d, input logic [1:0] s);
        int g;
        g = 0;
        @(negedge clk);
        while (!ready_v[0] && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("req_ready_timeout", 32'(g < 20), 32'd1);
        wr = w; rd = r; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        got_lat = 1;
        while (!response_v[0] && got_lat < 10) begin
            @(negedge clk);
            got_lat++;
        end
        check("resp_timeout", 32'(got_lat < 10), 32'd1);
        got_err   = err_v[0];
        got_rdata = rdata_v[0];
    endtask

    task automatic wait_all_ready();
        int g;
        g = 0;
        while (ready_v != 3'b111 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("all_ready_timeout", 32'(g < 20), 32'd1);
    endtask

    initial begin
        int first [3];
        int snap [3];

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready_v[0]), 32'd1);
        check("rst_response", 32'(response_v[0]), 32'd0);
        check("rst_rdata", 32'(rdata_v[0]), 32'd0);
        check("rst_err_count", 32'(cnt_v[0]), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // basic write then read
        do_req(1, 0, 8'd3, 16'hBEEF, 2'b11);
        check("t1_wr_lat", got_lat, 1);
        check("t1_wr_err", 32'(got_err), 0);
        do_req(0, 1, 8'd3, 16'h0000, 2'b00);
        check("t1_rd_lat", got_lat, 2);
        check("t1_rd_err", 32'(got_err), 0);
        check("t1_rd_data", 32'(got_rdata), 32'hBEEF);
        check("t1_ready_in_resp", 32'(ready_v[0]), 0);
        @(negedge clk);
        check("t1_ready_after", 32'(ready_v[0]), 1);

        // byte strobes
        do_req(1, 0, 8'd5, 16'h1234, 2'b11);
        do_req(1, 0, 8'd5, 16'hABCD, 2'b10);
        do_req(0, 1, 8'd5, 16'h0000, 2'b00);
        check("t2_strb_data", 32'(got_rdata), 32'hAB34);
        do_req(1, 0, 8'd5, 16'hFFFF, 2'b00);
        check("t2_nostrb_lat", got_lat, 1);
        check("t2_nostrb_err", 32'(got_err), 0);
        do_req(0, 1, 8'd5, 16'h0000, 2'b00);
        check("t2_nostrb_data", 32'(got_rdata), 32'hAB34);

        // errors
        do_req(0, 1, 8'd16, 16'h0000, 2'b00);
        check("t3_rd_oob_err", 32'(got_err), 1);
        check("t3_rd_oob_lat", got_lat, 1);
        check("t3_rdata_kept", 32'(got_rdata), 32'hAB34);
        do_req(1, 0, 8'd200, 16'h7777, 2'b11);
        check("t3_wr_oob_err", 32'(got_err), 1);
        do_req(1, 1, 8'd0, 16'h5555, 2'b11);
        check("t3_wrrd_err", 32'(got_err), 1);
        check("t3_err_count", 32'(cnt_v[0]), 3);
        check("t3_rdata_kept2", 32'(rdata_v[0]), 32'hAB34);
        do_req(0, 1, 8'd0, 16'h0000, 2'b00);
        check("t3_addr0_untouched", 32'(got_rdata), 32'h0000);
        check("t3_addr0_err", 32'(got_err), 0);
        do_req(0, 1, 8'd5, 16'h0000, 2'b00);
        check("t3_addr5_untouched", 32'(got_rdata), 32'hAB34);

        // saturation
        repeat (260) do_req(0, 1, 8'hFF, 16'h0000, 2'b00);
        check("t4_sat", 32'(cnt_v[0]), 255);
        do_req(1, 1, 8'd1, 16'h0000, 2'b11);
        check("t4_sat_hold", 32'(cnt_v[0]), 255);
        check("t4_sat_err", 32'(got_err), 1);

        // reset during a read
        @(negedge clk);
        while (!ready_v[0]) @(negedge clk);
        rd = 1'b1; addr = 8'd3;
        @(negedge clk);
        rd = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t5_no_resp", 32'(response_v[0]), 0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("t5_ready", 32'(ready_v[0]), 1);
        check("t5_err_count", 32'(cnt_v[0]), 0);
        do_req(0, 1, 8'd3, 16'h0000, 2'b00);
        check("t5_cleared", 32'(got_rdata), 32'h0000);
        check("t5_rd_lat", got_lat, 2);

        // latency sweep: all three idle and accept the same read
        wait_all_ready();
        do_req(1, 0, 8'd7, 16'h7777, 2'b11);
        @(negedge clk);
        wait_all_ready();
        first = '{0, 0, 0};
        rd = 1'b1; addr = 8'd7;
        @(negedge clk);
        rd = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            for (int k = 0; k < 3; k++)
                if (response_v[k] && first[k] == 0) first[k] = i;
            @(negedge clk);
        end
        check("t6_lat_l2", first[0], 2);
        check("t6_lat_l1", first[1], 1);
        check("t6_lat_l4", first[2], 4);
        check("t6_data_l1", 32'(rdata_v[1]), 32'h7777);
        check("t6_data_l4", 32'(rdata_v[2]), 32'h7777);

        // rd held high for 10 cycles: one response per acceptance
        wait_all_ready();
        snap = resp_cnt;
        rd = 1'b1; addr = 8'd7;
        repeat (10) @(negedge clk);
        rd = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_held_l2", resp_cnt[0] - snap[0], 4);
        check("t6_held_l1", resp_cnt[1] - snap[1], 5);
        check("t6_held_l4", resp_cnt[2] - snap[2], 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
